lampfpu_sqrt_gs_unit: RTL and testbench

Parametrised iterative Goldschmidt square-root and inverse-square-root unit for the lampFPU datapath. Successor to the fixed 8-bit fractional sqrt core, with:
- configurable significand, guard and output widths
- runtime sqrt/invsqrt mode
- bounded iteration count
- valid/ready handshakes on input and output
- in-block odd-exponent correction

It sits between operand unpack and the exponent/round stage. Lead-zero count and effective parity are exported so the exponent stage can adjust.

---
 rtl/lampfpu_sqrt_gs_unit.sv | 180 ++++++++++++++++++
 tb/tb_lampfpu_sqrt_gs_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lampfpu_sqrt_gs_unit.sv
// Iterative Goldschmidt sqrt / 1-sqrt on a normalised Q1 significand, with odd-exponent correction.
// One operation in flight; result held in DONE until out_ready_i, latency 3+3k cycles (1 for bypass).
module lampfpu_sqrt_gs_unit #(
  parameter int SIG_W    = 8,
  parameter int PREC_W   = 8,
  parameter int OUT_W    = 16,
  parameter int MAX_ITER = 4,
  parameter int ITER_CW  = $clog2(MAX_ITER + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  input  logic [SIG_W-1:0]           s_i,
  input  logic                       is_exp_odd_i,
  input  logic                       invSqrt_i,
  input  logic                       special_case_i,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic [OUT_W-1:0]           res_o,
  output logic [$clog2(SIG_W+1)-1:0] lz_o,
  output logic                       odd_o,
  output logic                       special_o,
  output logic [ITER_CW-1:0]         iter_o
);

  localparam int W    = SIG_W + PREC_W;
  localparam int W2   = 2 * W;
  localparam int W3   = 3 * W;
  localparam int LZ_W = $clog2(SIG_W + 1);

  localparam logic [W-1:0] ONE       = W'(1) << (W - 2);
  localparam logic [W-1:0] THREE     = W'(3) << (W - 2);
  localparam logic [W-1:0] SQRT2     = W'($rtoi(1.4142135623730951 * (2.0 ** (W - 2)) + 0.5));
  localparam logic [W-1:0] INV_SQRT2 = W'($rtoi(0.7071067811865476 * (2.0 ** (W - 2)) + 0.5));

  typedef enum logic [2:0] {
    IDLE, INIT, ITER_B, ITER_R, ITER_XY, FINAL, DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [SIG_W-1:0]   r_s;
  logic               r_odd_in, r_inv, r_spec;
  logic [W-1:0]       r_b, r_r, r_x, r_y;
  logic [LZ_W-1:0]    r_lz;
  logic               r_p;
  logic [ITER_CW-1:0] r_iter;
  logic [OUT_W-1:0]   r_res;
  logic [LZ_W-1:0]    r_lz_out;
  logic               r_odd_out, r_special;
  logic [ITER_CW-1:0] r_iter_out;

  function automatic logic [LZ_W-1:0] lzc(input logic [SIG_W-1:0] v);
    lzc = LZ_W'(SIG_W);
    for (int i = 0; i < SIG_W; i++) begin
      if (v[i]) lzc = LZ_W'(SIG_W - 1 - i);
    end
  endfunction

  logic [LZ_W-1:0]  w_lz;
  logic [SIG_W-1:0] w_norm;
  logic [W-1:0]     w_f, w_r0, w_x0, w_b_nxt, w_r_nxt, w_x_nxt, w_y_nxt;
  logic [W-1:0]     w_v, w_vc, w_vf;
  logic             w_bypass, w_conv;

  assign w_bypass = r_spec || (r_s == '0);
  assign w_conv   = (r_r == ONE) || (r_iter == ITER_CW'(MAX_ITER));

  // Q1.(SIG_W-1) -> Q2.(W-2): the normalised significand moves up by PREC_W-1 bits
  assign w_lz    = lzc(r_s);
  assign w_norm  = r_s << w_lz;
  assign w_f     = W'(w_norm) << (PREC_W - 1);
  assign w_r0    = (THREE - w_f) >> 1;
  assign w_x0    = W'((W2'(w_f) * W2'(w_r0)) >> (W - 2));

  assign w_b_nxt = W'((W3'(r_b) * W3'(r_r) * W3'(r_r)) >> (2 * W - 4));
  assign w_r_nxt = (THREE - r_b) >> 1;
  assign w_x_nxt = W'((W2'(r_x) * W2'(r_r)) >> (W - 2));
  assign w_y_nxt = W'((W2'(r_y) * W2'(r_r)) >> (W - 2));

  assign w_v  = r_inv ? r_y : r_x;
  assign w_vc = W'((W2'(w_v) * W2'(r_inv ? INV_SQRT2 : SQRT2)) >> (W - 2));
  assign w_vf = r_p ? w_vc : w_v;

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (in_valid_i) w_state_nxt = INIT;
      INIT:    w_state_nxt = w_bypass ? DONE : ITER_B;
      ITER_B:  w_state_nxt = w_conv ? FINAL : ITER_R;
      ITER_R:  w_state_nxt = ITER_XY;
      ITER_XY: w_state_nxt = ITER_B;
      FINAL:   w_state_nxt = DONE;
      DONE:    if (out_ready_i) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready_o  = (r_state == IDLE);
    out_valid_o = (r_state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s        <= '0;
      r_odd_in   <= 1'b0;
      r_inv      <= 1'b0;
      r_spec     <= 1'b0;
      r_b        <= '0;
      r_r        <= '0;
      r_x        <= '0;
      r_y        <= '0;
      r_lz       <= '0;
      r_p        <= 1'b0;
      r_iter     <= '0;
      r_res      <= '0;
      r_lz_out   <= '0;
      r_odd_out  <= 1'b0;
      r_special  <= 1'b0;
      r_iter_out <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid_i) begin
            r_s      <= s_i;
            r_odd_in <= is_exp_odd_i;
            r_inv    <= invSqrt_i;
            r_spec   <= special_case_i;
          end
        end
        INIT: begin
          if (w_bypass) begin
            r_res      <= '0;
            r_lz_out   <= '0;
            r_odd_out  <= 1'b0;
            r_special  <= 1'b1;
            r_iter_out <= '0;
          end else begin
            r_b    <= w_f;
            r_r    <= w_r0;
            r_y    <= w_r0;
            r_x    <= w_x0;
            r_lz   <= w_lz;
            r_p    <= r_odd_in ^ w_lz[0];
            r_iter <= '0;
          end
        end
        ITER_B:  if (!w_conv) r_b <= w_b_nxt;
        ITER_R:  r_r <= w_r_nxt;
        ITER_XY: begin
          r_x    <= w_x_nxt;
          r_y    <= w_y_nxt;
          r_iter <= r_iter + 1'b1;
        end
        FINAL: begin
          r_res      <= OUT_W'(w_vf >> (W - OUT_W));
          r_lz_out   <= r_lz;
          r_odd_out  <= r_p;
          r_special  <= 1'b0;
          r_iter_out <= r_iter;
        end
        default: ;
      endcase
    end
  end

  assign res_o     = r_res;
  assign lz_o      = r_lz_out;
  assign odd_o     = r_odd_out;
  assign special_o = r_special;
  assign iter_o    = r_iter_out;

endmodule

// File: tb/tb_lampfpu_sqrt_gs_unit.sv
// Bench for lampfpu_sqrt_gs_unit: directed vector table, randomized ops against a loop-level
// reference model, plus backpressure, reset-in-flight and a MAX_ITER=1 instance.
module tb_lampfpu_sqrt_gs_unit;
  localparam int SIG_W = 8, PREC_W = 8, W = 16, OUT_W = 16, MAX_ITER = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, in_valid, in_ready, odd_i, inv_i, spec_i, out_valid, out_ready;
  logic        odd_o, special_o;
  logic [7:0]  s_i;
  logic [15:0] res;
  logic [3:0]  lz;
  logic [2:0]  iter;

  logic        b_in_valid, b_in_ready, b_odd_i, b_inv_i, b_spec_i, b_out_valid, b_out_ready;
  logic        b_odd_o, b_special_o;
  logic [7:0]  b_s_i;
  logic [15:0] b_res;
  logic [3:0]  b_lz;
  logic [0:0]  b_iter;

  lampfpu_sqrt_gs_unit #(.SIG_W(SIG_W), .PREC_W(PREC_W), .OUT_W(OUT_W), .MAX_ITER(MAX_ITER)) u_dut (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready), .s_i(s_i),
    .is_exp_odd_i(odd_i), .invSqrt_i(inv_i), .special_case_i(spec_i),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .res_o(res), .lz_o(lz),
    .odd_o(odd_o), .special_o(special_o), .iter_o(iter));

  lampfpu_sqrt_gs_unit #(.SIG_W(SIG_W), .PREC_W(PREC_W), .OUT_W(OUT_W), .MAX_ITER(1)) u_dut1 (
    .clk(clk), .rst(rst), .in_valid_i(b_in_valid), .in_ready_o(b_in_ready), .s_i(b_s_i),
    .is_exp_odd_i(b_odd_i), .invSqrt_i(b_inv_i), .special_case_i(b_spec_i),
    .out_valid_o(b_out_valid), .out_ready_i(b_out_ready), .res_o(b_res), .lz_o(b_lz),
    .odd_o(b_odd_o), .special_o(b_special_o), .iter_o(b_iter));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_tol(input string name, input logic [63:0] got, input longint exp, input longint tol);
    longint g, d;
    n_tests++;
    g = longint'(got);
    d = (g > exp) ? g - exp : exp - g;
    if ($isunknown(got) || d > tol) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h +-%0d", name, got, exp, tol);
    end
  endtask

  // Reference: plain integer Goldschmidt loop on Q2.(W-2) values
  typedef struct {int res; int lz; int p; int sp; int it;} mres_t;

  function automatic mres_t model(input int s, input bit odd, input bit inv, input bit spec, input int maxit);
    mres_t  m;
    longint one, three, mask, f, b, r, x, y, v, sq, isq;
    int     norm;
    m     = '{default: 0};
    one   = longint'(1) << (W - 2);
    three = 3 * one;
    mask  = (longint'(1) << W) - 1;
    sq    = longint'($rtoi($sqrt(2.0) * one + 0.5));
    isq   = longint'($rtoi(one / $sqrt(2.0) + 0.5));
    if (spec || s == 0) begin
      m.sp = 1;
      return m;
    end
    norm = s;
    while ((norm & (1 << (SIG_W - 1))) == 0) begin
      norm = norm << 1;
      m.lz++;
    end
    f = longint'(norm) << (PREC_W - 1);
    b = f;
    r = (three - f) >> 1;
    y = r;
    x = ((f * r) >> (W - 2)) & mask;
    while (r != one && m.it < maxit) begin
      b = ((b * r * r) >> (2 * W - 4)) & mask;
      r = (three - b) >> 1;
      x = ((x * r) >> (W - 2)) & mask;
      y = ((y * r) >> (W - 2)) & mask;
      m.it++;
    end
    v   = inv ? y : x;
    m.p = int'(odd) ^ (m.lz & 1);
    if (m.p != 0) v = ((v * (inv ? isq : sq)) >> (W - 2)) & mask;
    m.res = int'(v >> (W - OUT_W));
    return m;
  endfunction

  logic [15:0] g_res;
  logic [3:0]  g_lz;
  logic        g_odd, g_sp;
  logic [2:0]  g_it;
  int          g_lat;

  task automatic run_op(input logic [7:0] s, input bit odd, input bit inv, input bit spec);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1; s_i = s; odd_i = odd; inv_i = inv; spec_i = spec;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; s_i = 8'($urandom); odd_i = 1'($urandom); inv_i = 1'($urandom); spec_i = 1'($urandom);
    g_lat = 0;
    while (out_valid !== 1'b1 && g_lat < 100) begin
      @(posedge clk);
      g_lat++;
      @(negedge clk);
    end
    if (out_valid !== 1'b1) check("out_valid_timeout", out_valid, 1);
    g_res = res; g_lz = lz; g_odd = odd_o; g_sp = special_o; g_it = iter;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_drop", out_valid, 0);
  endtask

  typedef struct {
    logic [7:0] s;
    bit odd, inv, spec;
    int res, tol, lz, p, sp, it, lat;
  } vec_t;

  vec_t  vecs[10];
  mres_t m;
  logic [15:0] held;
  int    lat;
  bit    saw_valid;

  initial begin
    vecs[0] = '{8'h80, 0, 0, 0, 'h4000, 0, 0, 0, 0, 0, 3};
    vecs[1] = '{8'h80, 1, 0, 0, 'h5A82, 1, 0, 1, 0, 0, 3};
    vecs[2] = '{8'h80, 1, 1, 0, 'h2D41, 1, 0, 1, 0, 0, 3};
    vecs[3] = '{8'h80, 0, 1, 0, 'h4000, 0, 0, 0, 0, 0, 3};
    vecs[4] = '{8'hC0, 0, 0, 0, 'h4E62, 2, 0, 0, 0, 4, 15};
    vecs[5] = '{8'hC0, 0, 1, 0, 'h3442, 2, 0, 0, 0, 4, 15};
    vecs[6] = '{8'h01, 0, 0, 0, 'h5A82, 1, 7, 1, 0, 0, 3};
    vecs[7] = '{8'h01, 1, 0, 0, 'h4000, 0, 7, 0, 0, 0, 3};
    vecs[8] = '{8'hC0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1};
    vecs[9] = '{8'h00, 1, 1, 0, 0, 0, 0, 0, 1, 0, 1};

    rst = 1'b1; in_valid = 1'b0; s_i = '0; odd_i = 1'b0; inv_i = 1'b0; spec_i = 1'b0; out_ready = 1'b0;
    b_in_valid = 1'b0; b_s_i = '0; b_odd_i = 1'b0; b_inv_i = 1'b0; b_spec_i = 1'b0; b_out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_res", res, 0);
    check("rst_lz", lz, 0);
    check("rst_odd", odd_o, 0);
    check("rst_special", special_o, 0);
    check("rst_iter", iter, 0);
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].s, vecs[i].odd, vecs[i].inv, vecs[i].spec);
      check_tol("vec_res", g_res, vecs[i].res, vecs[i].tol);
      check("vec_lz", g_lz, vecs[i].lz);
      check("vec_odd", g_odd, vecs[i].p);
      check("vec_special", g_sp, vecs[i].sp);
      check("vec_iter", g_it, vecs[i].it);
      check("vec_latency", g_lat, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      logic [7:0] s;
      bit o, v, sp;
      s  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 9) == 0) s = 8'h00;
      o  = 1'($urandom);
      v  = 1'($urandom);
      sp = ($urandom_range(0, 7) == 0);
      m  = model(int'(s), o, v, sp, MAX_ITER);
      run_op(s, o, v, sp);
      check("rnd_res", g_res, m.res);
      check("rnd_lz", g_lz, m.lz);
      check("rnd_odd", g_odd, m.p);
      check("rnd_special", g_sp, m.sp);
      check("rnd_iter", g_it, m.it);
      check("rnd_latency", g_lat, (m.sp != 0) ? 1 : 3 + 3 * m.it);
    end

    // Backpressure: hold the result, poke in_valid with a different operand meanwhile
    @(negedge clk);
    in_valid = 1'b1; s_i = 8'hC0; odd_i = 1'b0; inv_i = 1'b0; spec_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("bp_valid", out_valid, 1);
    held = res;
    check("bp_res", held, model(8'hC0, 0, 0, 0, MAX_ITER).res);
    for (int c = 0; c < 10; c++) begin
      in_valid = 1'b1; s_i = 8'h80; odd_i = 1'b1; inv_i = 1'b1;
      @(posedge clk);
      @(negedge clk);
      check("bp_hold_res", res, held);
      check("bp_hold_valid", out_valid, 1);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 0);
    check("bp_release_ready", in_ready, 1);
    m = model(8'hA5, 1, 0, 0, MAX_ITER);
    run_op(8'hA5, 1, 0, 0);
    check("bp_next_res", g_res, m.res);
    check("bp_next_iter", g_it, m.it);

    // Reset while in ITER_R; outputs still hold the previous result beforehand
    @(negedge clk);
    in_valid = 1'b1; s_i = 8'hC0; odd_i = 1'b1; inv_i = 1'b0; spec_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rstmid_in_ready", in_ready, 1);
    check("rstmid_out_valid", out_valid, 0);
    check("rstmid_res", res, 0);
    check("rstmid_lz", lz, 0);
    check("rstmid_odd", odd_o, 0);
    check("rstmid_special", special_o, 0);
    check("rstmid_iter", iter, 0);
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid !== 1'b0) saw_valid = 1'b1;
    end
    check("rstmid_no_valid", saw_valid, 0);

    // MAX_ITER=1 instance: iteration cap reached after one pass
    @(negedge clk);
    b_in_valid = 1'b1; b_s_i = 8'hC0; b_odd_i = 1'b0; b_inv_i = 1'b0; b_spec_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    b_in_valid = 1'b0;
    lat = 0;
    while (b_out_valid !== 1'b1 && lat < 100) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    check("cap1_latency", lat, 6);
    check("cap1_iter", b_iter, 1);
    check("cap1_res", b_res, model(8'hC0, 0, 0, 0, 1).res);
    b_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    b_out_ready = 1'b0;
    check("cap1_drop", b_out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

endmodule
